// File: rtl/lcd_display_scheduler_pkg.sv
// Shared constants for the LCD display scheduler: state codes, driver data width,
// default step timings and line names.
package lcd_sched_pkg;

    localparam int LCD_DATA_W = 18;

    localparam int DEF_INIT_WAIT  = 32;
    localparam int DEF_LINE_WAIT  = 8;
    localparam int DEF_WRITE_WAIT = 128;
    localparam int DEF_CNT_W      = 8;

    localparam logic LINE_TOP = 1'b0;
    localparam logic LINE_BOT = 1'b1;

    localparam logic [2:0] ST_INIT_RST   = 3'd0;
    localparam logic [2:0] ST_INIT_WAIT  = 3'd1;
    localparam logic [2:0] ST_IDLE       = 3'd2;
    localparam logic [2:0] ST_SET_LINE   = 3'd3;
    localparam logic [2:0] ST_LINE_WAIT  = 3'd4;
    localparam logic [2:0] ST_WRITE      = 3'd5;
    localparam logic [2:0] ST_WRITE_WAIT = 3'd6;
    localparam logic [2:0] ST_DONE       = 3'd7;

endpackage

// File: rtl/lcd_display_scheduler_if.sv
// Requester and LCD-driver signal bundle; the scheduler uses the slave view,
// whoever drives requests and watches the driver pins uses the master view.
interface lcd_display_scheduler_if
    import lcd_sched_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int DATA_W = LCD_DATA_W
);
    logic [NREQ-1:0]        req;
    logic [NREQ*DATA_W-1:0] req_data;
    logic [NREQ-1:0]        req_line;
    logic [NREQ-1:0]        gnt;
    logic [NREQ-1:0]        done;
    logic                   busy;
    logic                   lcd_rst;
    logic [DATA_W-1:0]      lcd_data;
    logic                   lcd_line;
    logic                   lcd_set_line;

    modport master (
        output req, req_data, req_line,
        input  gnt, done, busy, lcd_rst, lcd_data, lcd_line, lcd_set_line
    );

    modport slave (
        input  req, req_data, req_line,
        output gnt, done, busy, lcd_rst, lcd_data, lcd_line, lcd_set_line
    );
endinterface

// File: rtl/lcd_display_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first set request bit after rr_ptr, wrapping
// modulo NREQ, so the previous winner has lowest priority.
module rr_arbiter
    import lcd_sched_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic             valid,
    output logic [IDX_W-1:0] winner,
    output logic [NREQ-1:0]  onehot
);

    logic [IDX_W-1:0] idx;

    // Walk from farthest to nearest so the nearest set bit is the last one written.
    always_comb begin
        valid  = 1'b0;
        winner = '0;
        onehot = '0;
        idx    = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = IDX_W'((int'(rr_ptr) + k) % NREQ);
            if (req[idx]) begin
                valid  = 1'b1;
                winner = idx;
            end
        end
        if (valid) begin
            onehot[winner] = 1'b1;
        end
    end

endmodule

// File: rtl/lcd_display_scheduler.sv
// Shares one 2x16 LCD character driver between NREQ requesters, sequencing the
// driver with fixed hold times because it has no busy/ack handshake.
module lcd_display_scheduler
    import lcd_sched_pkg::*;
#(
    parameter int NREQ       = 2,
    parameter int DATA_W     = LCD_DATA_W,
    parameter int INIT_WAIT  = DEF_INIT_WAIT,
    parameter int LINE_WAIT  = DEF_LINE_WAIT,
    parameter int WRITE_WAIT = DEF_WRITE_WAIT,
    parameter int CNT_W      = DEF_CNT_W
) (
    input logic clk,
    input logic rst,
    lcd_display_scheduler_if.slave sched
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [2:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]  rr_ptr;
    logic [DATA_W-1:0] sel_data;
    logic              sel_line;
    logic [DATA_W-1:0] last_data;

    logic [NREQ-1:0]   gnt_q;
    logic [NREQ-1:0]   done_q;
    logic              lcd_rst_q;
    logic [DATA_W-1:0] lcd_data_q;
    logic              lcd_line_q;
    logic              lcd_set_line_q;

    logic              arb_valid;
    logic [IDX_W-1:0]  arb_winner;
    logic [NREQ-1:0]   arb_onehot;

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_arbiter (
        .req    (sched.req),
        .rr_ptr (rr_ptr),
        .valid  (arb_valid),
        .winner (arb_winner),
        .onehot (arb_onehot)
    );

    // Outputs are registered and updated on the edge that enters each state, so
    // they are valid for exactly the cycles spent in that state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= ST_INIT_RST;
            cnt            <= '0;
            rr_ptr         <= IDX_W'(NREQ - 1);
            sel_data       <= '0;
            sel_line       <= 1'b0;
            last_data      <= '0;
            gnt_q          <= '0;
            done_q         <= '0;
            lcd_rst_q      <= 1'b0;
            lcd_data_q     <= '0;
            lcd_line_q     <= 1'b0;
            lcd_set_line_q <= 1'b0;
        end else begin
            case (state)
                ST_INIT_RST: begin
                    if (cnt == CNT_W'(2)) begin
                        lcd_rst_q <= 1'b0;
                        cnt       <= '0;
                        state     <= ST_INIT_WAIT;
                    end else begin
                        lcd_rst_q <= 1'b1;
                        cnt       <= cnt + 1'b1;
                    end
                end
                ST_INIT_WAIT: begin
                    if (cnt == CNT_W'(INIT_WAIT - 1)) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (arb_valid) begin
                        gnt_q          <= arb_onehot;
                        rr_ptr         <= arb_winner;
                        sel_data       <= sched.req_data[int'(arb_winner) * DATA_W +: DATA_W];
                        sel_line       <= sched.req_line[arb_winner];
                        lcd_line_q     <= sched.req_line[arb_winner];
                        lcd_set_line_q <= 1'b1;
                        cnt            <= '0;
                        state          <= ST_SET_LINE;
                    end
                end
                ST_SET_LINE: begin
                    lcd_set_line_q <= 1'b0;
                    cnt            <= '0;
                    state          <= ST_LINE_WAIT;
                end
                ST_LINE_WAIT: begin
                    if (cnt == CNT_W'(LINE_WAIT - 1)) begin
                        cnt <= '0;
                        // The driver ignores a repeat of what it already shows.
                        if (sel_data == last_data) begin
                            gnt_q  <= '0;
                            done_q <= gnt_q;
                            state  <= ST_DONE;
                        end else begin
                            lcd_data_q <= sel_data;
                            last_data  <= sel_data;
                            state      <= ST_WRITE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_WRITE: begin
                    cnt   <= '0;
                    state <= ST_WRITE_WAIT;
                end
                ST_WRITE_WAIT: begin
                    if (cnt == CNT_W'(WRITE_WAIT - 1)) begin
                        cnt    <= '0;
                        gnt_q  <= '0;
                        done_q <= gnt_q;
                        state  <= ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    done_q <= '0;
                    cnt    <= '0;
                    state  <= ST_IDLE;
                end
                default: begin
                    cnt   <= '0;
                    state <= ST_INIT_RST;
                end
            endcase
        end
    end

    assign sched.gnt          = gnt_q;
    assign sched.done         = done_q;
    assign sched.busy         = (state != ST_IDLE);
    assign sched.lcd_rst      = lcd_rst_q;
    assign sched.lcd_data     = lcd_data_q;
    assign sched.lcd_line     = lcd_line_q;
    assign sched.lcd_set_line = lcd_set_line_q;

endmodule

// File: tb/tb_lcd_display_scheduler.sv
// Self-checking bench for lcd_display_scheduler: directed service table, hand-written
// drop/reset sequences and randomized services against a transaction-level model.
module tb_lcd_display_scheduler;
    import lcd_sched_pkg::*;

    localparam int NREQ      = 2;
    localparam int DW        = LCD_DATA_W;
    localparam int SKIP_LAT  = 1 + 1 + DEF_LINE_WAIT + 1;
    localparam int WRITE_LAT = 1 + 1 + DEF_LINE_WAIT + 1 + DEF_WRITE_WAIT + 1;
    localparam int MAX_CYC   = 400;

    logic clk = 1'b0;
    logic rst;

    lcd_display_scheduler_if #(.NREQ(NREQ), .DATA_W(DW)) ifc ();

    lcd_display_scheduler #(
        .NREQ       (NREQ),
        .DATA_W     (DW),
        .INIT_WAIT  (DEF_INIT_WAIT),
        .LINE_WAIT  (DEF_LINE_WAIT),
        .WRITE_WAIT (DEF_WRITE_WAIT),
        .CNT_W      (DEF_CNT_W)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .sched (ifc)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int            model_rr;
    logic [DW-1:0] model_last;

    typedef struct {
        logic [1:0]    reqs;
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
        logic          l0;
        logic          l1;
        bit            keep;
        logic [1:0]    exp_gnt;
        int            exp_lat;
        logic [DW-1:0] exp_data;
        logic          exp_line;
        int            exp_writes;
    } vec_t;

    vec_t vecs[6];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual %0h required %0h", name, actual, expected);
        end
    endtask

    // Reference model: round-robin order from the last winner, write skipped when the
    // value equals what the driver already shows.
    function automatic int modelWinner(input logic [1:0] reqs);
        for (int k = 1; k <= NREQ; k++) begin
            if (((reqs >> ((model_rr + k) % NREQ)) & 2'b01) != 2'b00) return (model_rr + k) % NREQ;
        end
        return 0;
    endfunction

    task automatic modelService(input logic [1:0] reqs, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                                input logic l0, input logic l1,
                                output logic [1:0] g, output int lat, output logic [DW-1:0] data,
                                output logic line, output int writes);
        int w;
        logic [DW-1:0] sel;
        w    = modelWinner(reqs);
        sel  = (w == 0) ? d0 : d1;
        line = (w == 0) ? l0 : l1;
        g    = 2'(1 << w);
        if (sel == model_last) begin
            lat    = SKIP_LAT;
            writes = 0;
        end else begin
            lat        = WRITE_LAT;
            writes     = 1;
            model_last = sel;
        end
        data     = model_last;
        model_rr = w;
    endtask

    task automatic applyReset(input string tag);
        int rst_high, wait_cnt, other, cycles;
        bit seen;
        rst = 1'b0;
        #1;
        checkOutput({tag, "_gnt"}, 32'(ifc.gnt), 0);
        checkOutput({tag, "_done"}, 32'(ifc.done), 0);
        checkOutput({tag, "_busy"}, 32'(ifc.busy), 1);
        checkOutput({tag, "_lcd_rst"}, 32'(ifc.lcd_rst), 0);
        checkOutput({tag, "_lcd_data"}, 32'(ifc.lcd_data), 0);
        checkOutput({tag, "_lines"}, 32'({ifc.lcd_line, ifc.lcd_set_line}), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        rst_high = 0; wait_cnt = 0; other = 0; cycles = 0; seen = 1'b0;
        do begin
            @(negedge clk);
            cycles++;
            if (ifc.lcd_rst) begin
                rst_high++;
                seen = 1'b1;
            end else if (seen && ifc.busy) begin
                wait_cnt++;
            end
            if (ifc.gnt != 0 || ifc.done != 0 || ifc.lcd_set_line || ifc.lcd_line || ifc.lcd_data != 0)
                other++;
        end while (!(seen && !ifc.busy) && cycles < 200);
        checkOutput({tag, "_rst_pulse_len"}, 32'(rst_high), 2);
        checkOutput({tag, "_init_wait_len"}, 32'(wait_cnt), DEF_INIT_WAIT);
        checkOutput({tag, "_quiet_during_init"}, 32'(other), 0);
        checkOutput({tag, "_idle_after_init"}, 32'(ifc.busy), 0);
        model_rr   = NREQ - 1;
        model_last = '0;
    endtask

    // Starts in an IDLE cycle (cycle 1), returns in the following IDLE cycle.
    task automatic applyStimulus(input logic [1:0] reqs, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                                 input logic l0, input logic l1, input bit keep,
                                 input int drop_cyc, input int change_cyc, input logic [DW-1:0] new_d0,
                                 output int lat, output logic [1:0] gnt_seen, output logic [1:0] done_seen,
                                 output int pulses, output logic line_seen, output int writes);
        logic [DW-1:0] prev_data;
        ifc.req      = reqs;
        ifc.req_data = {d1, d0};
        ifc.req_line = {l1, l0};
        lat = 1; gnt_seen = '0; done_seen = '0; pulses = 0; line_seen = 1'b0; writes = 0;
        prev_data = ifc.lcd_data;
        while (done_seen == 2'b00 && lat < MAX_CYC) begin
            @(negedge clk);
            lat++;
            if (lat == drop_cyc) ifc.req = '0;
            if (lat == change_cyc) ifc.req_data[DW-1:0] = new_d0;
            if (gnt_seen == 2'b00) gnt_seen = ifc.gnt;
            if (ifc.lcd_set_line) begin
                pulses++;
                line_seen = ifc.lcd_line;
            end
            if (ifc.lcd_data !== prev_data) begin
                writes++;
                prev_data = ifc.lcd_data;
            end
            done_seen = ifc.done;
        end
        if (!keep) ifc.req = '0;
        @(negedge clk);
    endtask

    task automatic compareService(input string tag, input int lat, input logic [1:0] g, input logic [1:0] d,
                                  input int pulses, input logic line, input int writes,
                                  input logic [1:0] exp_g, input int exp_lat, input logic [DW-1:0] exp_data,
                                  input logic exp_line, input int exp_writes);
        checkOutput({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        checkOutput({tag, "_gnt"}, 32'(g), 32'(exp_g));
        checkOutput({tag, "_done"}, 32'(d), 32'(exp_g));
        checkOutput({tag, "_lcd_data"}, 32'(ifc.lcd_data), 32'(exp_data));
        checkOutput({tag, "_set_line_pulses"}, 32'(pulses), 1);
        checkOutput({tag, "_lcd_line"}, 32'(line), 32'(exp_line));
        checkOutput({tag, "_writes"}, 32'(writes), 32'(exp_writes));
    endtask

    initial begin
        int lat, pulses, writes, m_lat, m_writes, done_acc;
        logic [1:0] g, d, m_g, reqs;
        logic line, m_line, l0, l1;
        logic [DW-1:0] m_data, d0, d1;

        ifc.req      = '0;
        ifc.req_data = '0;
        ifc.req_line = '0;
        rst = 1'b1;
        #2;
        applyReset("por");

        vecs[0] = '{2'b01, 18'h2A5C3, 18'h00000, 1'b1, 1'b0, 1'b0, 2'b01, WRITE_LAT, 18'h2A5C3, 1'b1, 1};
        vecs[1] = '{2'b11, 18'h00001, 18'h3FFFF, 1'b0, 1'b1, 1'b1, 2'b10, WRITE_LAT, 18'h3FFFF, 1'b1, 1};
        vecs[2] = '{2'b11, 18'h00001, 18'h3FFFF, 1'b0, 1'b1, 1'b1, 2'b01, WRITE_LAT, 18'h00001, 1'b0, 1};
        vecs[3] = '{2'b11, 18'h00001, 18'h3FFFF, 1'b0, 1'b1, 1'b0, 2'b10, WRITE_LAT, 18'h3FFFF, 1'b1, 1};
        vecs[4] = '{2'b01, 18'h00001, 18'h00000, 1'b0, 1'b0, 1'b0, 2'b01, WRITE_LAT, 18'h00001, 1'b0, 1};
        vecs[5] = '{2'b01, 18'h00001, 18'h00000, 1'b1, 1'b0, 1'b0, 2'b01, SKIP_LAT,  18'h00001, 1'b1, 0};

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].reqs, vecs[i].d0, vecs[i].d1, vecs[i].l0, vecs[i].l1, vecs[i].keep,
                          0, 0, '0, lat, g, d, pulses, line, writes);
            modelService(vecs[i].reqs, vecs[i].d0, vecs[i].d1, vecs[i].l0, vecs[i].l1,
                         m_g, m_lat, m_data, m_line, m_writes);
            compareService($sformatf("vec%0d", i), lat, g, d, pulses, line, writes,
                           vecs[i].exp_gnt, vecs[i].exp_lat, vecs[i].exp_data, vecs[i].exp_line, vecs[i].exp_writes);
        end

        // Request dropped 5 cycles into WRITE_WAIT, data changed right after grant.
        modelService(2'b01, 18'h12345, 18'h00000, 1'b0, 1'b0, m_g, m_lat, m_data, m_line, m_writes);
        applyStimulus(2'b01, 18'h12345, 18'h00000, 1'b0, 1'b0, 1'b0,
                      17, 3, 18'h0ABCD, lat, g, d, pulses, line, writes);
        compareService("drop", lat, g, d, pulses, line, writes, m_g, m_lat, m_data, m_line, m_writes);

        // Reset pulled during WRITE_WAIT with requester 1 still pending.
        ifc.req      = 2'b10;
        ifc.req_data = {18'h0F0F0, 18'h00000};
        ifc.req_line = 2'b00;
        done_acc = 0;
        repeat (50) begin
            @(negedge clk);
            if (ifc.done != 0) done_acc++;
        end
        checkOutput("midrst_gnt_before", 32'(ifc.gnt), 32'(2'b10));
        applyReset("midrst");
        checkOutput("midrst_no_done", 32'(done_acc), 0);
        modelService(2'b10, 18'h00000, 18'h0F0F0, 1'b0, 1'b0, m_g, m_lat, m_data, m_line, m_writes);
        applyStimulus(2'b10, 18'h00000, 18'h0F0F0, 1'b0, 1'b0, 1'b0,
                      0, 0, '0, lat, g, d, pulses, line, writes);
        compareService("after_rst", lat, g, d, pulses, line, writes, m_g, m_lat, m_data, m_line, m_writes);

        for (int n = 0; n < 10; n++) begin
            reqs = 2'($urandom_range(1, 3));
            d0   = ($urandom_range(0, 2) == 0) ? model_last : DW'($urandom);
            d1   = ($urandom_range(0, 2) == 0) ? model_last : DW'($urandom);
            l0   = 1'($urandom);
            l1   = 1'($urandom);
            modelService(reqs, d0, d1, l0, l1, m_g, m_lat, m_data, m_line, m_writes);
            applyStimulus(reqs, d0, d1, l0, l1, 1'b0, 0, 0, '0, lat, g, d, pulses, line, writes);
            compareService($sformatf("rand%0d", n), lat, g, d, pulses, line, writes,
                           m_g, m_lat, m_data, m_line, m_writes);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
